// File: rtl/digest_tx.sv
// digest_tx: serialises a 160-bit SHA-1 digest (H0..H4) into five 32-bit
// stream words. One digest is held in the active buffer while it is being
// sent. A second digest can wait in a one-deep pending buffer. A digest that
// arrives while both buffers are occupied is dropped and counted.
//
// Stream handshake: m_tvalid is high whenever the FSM is in SEND. While
// m_tvalid is high and m_tready is low, m_tdata and m_tlast hold their values.
// A beat transfers on a rising clk edge where m_tvalid && m_tready. m_tlast
// marks the fifth word (H4) of every digest.
module digest_tx (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [159:0] digest_in,
    input  logic         digest_valid,
    output logic [31:0]  m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic         busy,
    output logic         overflow,
    input  logic         ovf_clr,
    output logic [7:0]   drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [159:0] act_buf_q, act_buf_d;
    logic [159:0] pend_buf_q, pend_buf_d;
    logic         pend_full_q, pend_full_d;
    logic         overflow_q, overflow_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;

    logic         beat;
    logic         final_beat;
    logic         drop;

    // A final beat frees the active buffer in the same edge, so a digest
    // arriving then always has somewhere to go and is never dropped.
    assign beat       = (state_q == SEND) && m_tready;
    assign final_beat = beat && (cnt_q == 3'd4);
    assign drop       = (state_q == SEND) && !final_beat && digest_valid && pend_full_q;

    assign m_tvalid = (state_q == SEND);
    assign m_tlast  = (state_q == SEND) && (cnt_q == 3'd4);
    assign busy     = (state_q == SEND) || pend_full_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Word select: H0 first, H4 last.
    always_comb begin
        m_tdata = 32'd0;
        case (cnt_q)
            3'd0:    m_tdata = act_buf_q[159:128];
            3'd1:    m_tdata = act_buf_q[127:96];
            3'd2:    m_tdata = act_buf_q[95:64];
            3'd3:    m_tdata = act_buf_q[63:32];
            3'd4:    m_tdata = act_buf_q[31:0];
            default: m_tdata = 32'd0;
        endcase
    end

    // FSM next state, word counter and the two digest buffers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_buf_d   = act_buf_q;
        pend_buf_d  = pend_buf_q;
        pend_full_d = pend_full_q;
        case (state_q)
            IDLE: begin
                if (digest_valid) begin
                    act_buf_d = digest_in;
                    cnt_d     = 3'd0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (final_beat) begin
                    if (pend_full_q) begin
                        // Promote the waiting digest; a new arrival refills pending.
                        act_buf_d   = pend_buf_q;
                        cnt_d       = 3'd0;
                        pend_full_d = digest_valid;
                        if (digest_valid) begin
                            pend_buf_d = digest_in;
                        end
                    end else if (digest_valid) begin
                        // Go straight into the new digest without an idle cycle.
                        act_buf_d = digest_in;
                        cnt_d     = 3'd0;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (digest_valid && !pend_full_q) begin
                        pend_buf_d  = digest_in;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Sticky overflow and saturating drop counter. A drop in the same cycle
    // as ovf_clr wins and leaves a count of one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            act_buf_q   <= 160'd0;
            pend_buf_q  <= 160'd0;
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_buf_q   <= act_buf_d;
            pend_buf_q  <= pend_buf_d;
            pend_full_q <= pend_full_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_digest_tx.sv
// Bench for digest_tx: table of single-digest vectors under different sink
// behaviours, plus directed sequences for back-to-back, overflow, clear and
// reset corner cases. Every word seen on the stream is checked against a
// queue of expected {tlast, tdata} values.
module tb_digest_tx;

    logic         clk;
    logic         rst_n;
    logic [159:0] digest_in;
    logic         digest_valid;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         busy;
    logic         overflow;
    logic         ovf_clr;
    logic [7:0]   drop_cnt;

    digest_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digest_in    (digest_in),
        .digest_valid (digest_valid),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .drop_cnt     (drop_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sink ready driver ----------------
    // mode 0: always ready, 1: pattern 1,0,0, 2: random, 3: never ready
    int ready_mode = 0;
    int pat = 0;
    initial m_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: begin
                m_tready = (pat == 0);
                pat = (pat == 2) ? 0 : pat + 1;
            end
            2: m_tready = ($urandom_range(0, 1) == 1);
            default: m_tready = 1'b0;
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_digest(input logic [159:0] d);
        logic [31:0] w;
        for (int i = 0; i < 5; i++) begin
            w = d[159 - 32*i -: 32];
            exp_q.push_back({(i == 4), w});
        end
    endtask

    // Monitor: sampled on the falling edge, a word with valid && ready here
    // transfers on the next rising edge (unless reset is asserted).
    int          beat_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] first_data, last_data;
    logic        stall_q = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (stall_q && m_tvalid) begin
                chk("stall_tdata", m_tdata, hold_data);
                chk("stall_tlast", m_tlast, hold_last);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", m_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_tlast, m_tdata}, e);
                end
                beat_cnt++;
                if (beat_cnt == 1) begin
                    first_cyc  = cyc;
                    first_data = m_tdata;
                end
                last_cyc  = cyc;
                last_data = m_tdata;
            end
            stall_q   = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_last = m_tlast;
        end else begin
            stall_q = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic [159:0] d);
        digest_in    = d;
        digest_valid = 1'b1;
        @(posedge clk);
        #1;
        digest_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1'b1);
        step(1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [159:0] digest;
        int           mode;
        logic [31:0]  exp_h0;
        logic [31:0]  exp_h4;
    } vec_t;

    vec_t vecs[4];

    localparam logic [159:0] D_SHA = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    initial begin
        logic [159:0] a, b, c, d;

        vecs[0] = '{D_SHA, 0, 32'h67452301, 32'hC3D2E1F0};
        vecs[1] = '{D_SHA, 1, 32'h67452301, 32'hC3D2E1F0};
        vecs[2] = '{160'hDEADBEEF_00000001_FFFFFFFF_80000000_0000CAFE, 2, 32'hDEADBEEF, 32'h0000CAFE};
        vecs[3] = '{160'h00000000_11111111_22222222_33333333_44444444, 1, 32'h00000000, 32'h44444444};

        // Reset with a strobe held high: it must be ignored.
        rst_n        = 1'b0;
        ovf_clr      = 1'b0;
        digest_valid = 1'b1;
        digest_in    = D_SHA;
        step(3);
        digest_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'd0);
        step(2);

        // Reference digest, sink always ready: latency 1, five consecutive beats.
        ready_mode = 0;
        step(2);
        push_digest(D_SHA);
        strobe(D_SHA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ref_tvalid", m_tvalid, 1'b1);
            chk("ref_tlast", m_tlast, (i == 4));
        end
        @(negedge clk);
        chk("ref_idle_tvalid", m_tvalid, 1'b0);
        chk("ref_idle_busy", busy, 1'b0);
        step(1);

        // Table-driven single digests under various sink behaviours.
        foreach (vecs[i]) begin
            ready_mode = vecs[i].mode;
            step(2);
            beat_cnt = 0;
            push_digest(vecs[i].digest);
            strobe(vecs[i].digest);
            drain();
            chk("vec_beats", beat_cnt, 5);
            chk("vec_h0", first_data, vecs[i].exp_h0);
            chk("vec_h4", last_data, vecs[i].exp_h4);
            chk("vec_overflow", overflow, 1'b0);
        end

        // Random digests with a random sink.
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom, $urandom};
            beat_cnt = 0;
            push_digest(a);
            strobe(a);
            drain();
            chk("rnd_beats", beat_cnt, 5);
        end

        // A then B strobed while A's word 2 is on the bus: ten beats, no gap.
        ready_mode = 0;
        step(2);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        beat_cnt = 0;
        push_digest(a);
        push_digest(b);
        strobe(a);
        step(2);
        strobe(b);
        drain();
        chk("ab_beats", beat_cnt, 10);
        chk("ab_span", last_cyc - first_cyc, 9);
        chk("ab_overflow", overflow, 1'b0);

        // B arrives exactly on A's final beat with pending empty: no bubble.
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        beat_cnt = 0;
        push_digest(a);
        push_digest(b);
        strobe(a);
        step(4);
        strobe(b);
        drain();
        chk("fin_empty_beats", beat_cnt, 10);
        chk("fin_empty_span", last_cyc - first_cyc, 9);
        chk("fin_empty_overflow", overflow, 1'b0);

        // C arrives on A's final beat while B is pending: no drop, 15 beats.
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom, $urandom};
        beat_cnt = 0;
        push_digest(a);
        push_digest(b);
        push_digest(c);
        strobe(a);
        strobe(b);
        step(3);
        strobe(c);
        drain();
        chk("fin_full_beats", beat_cnt, 15);
        chk("fin_full_span", last_cyc - first_cyc, 14);
        chk("fin_full_overflow", overflow, 1'b0);
        chk("fin_full_drop_cnt", drop_cnt, 8'd0);

        // A, B, C on consecutive cycles with the sink stalled: C is dropped.
        ready_mode = 3;
        step(2);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom, $urandom};
        push_digest(a);
        push_digest(b);
        strobe(a);
        strobe(b);
        strobe(c);
        @(negedge clk);
        chk("abc_overflow", overflow, 1'b1);
        chk("abc_drop_cnt", drop_cnt, 8'd1);
        chk("abc_busy", busy, 1'b1);
        chk("abc_head", m_tdata, a[159:128]);
        ready_mode = 0;
        drain();
        chk("abc_overflow_kept", overflow, 1'b1);

        // Second drop counts up, then a drop coincident with ovf_clr wins.
        ready_mode = 3;
        step(2);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        push_digest(a);
        push_digest(b);
        strobe(a);
        strobe(b);
        strobe(c);
        @(negedge clk);
        chk("drop2_cnt", drop_cnt, 8'd2);
        step(0);
        ovf_clr = 1'b1;
        strobe(d);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_drop_overflow", overflow, 1'b1);
        chk("clr_drop_cnt", drop_cnt, 8'd1);
        step(0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_overflow", overflow, 1'b0);
        chk("clr_drop_cnt0", drop_cnt, 8'd0);
        ready_mode = 0;
        drain();

        // Drop counter saturates at 255.
        ready_mode = 3;
        step(2);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        push_digest(a);
        push_digest(b);
        strobe(a);
        strobe(b);
        for (int i = 0; i < 260; i++) begin
            strobe({$urandom, $urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        chk("sat_drop_cnt", drop_cnt, 8'd255);
        chk("sat_overflow", overflow, 1'b1);
        step(0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr_cnt", drop_cnt, 8'd0);
        ready_mode = 0;
        drain();

        // Reset after beat 2 with pending full: everything is abandoned.
        ready_mode = 0;
        step(2);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        beat_cnt = 0;
        push_digest(a);
        push_digest(b);
        strobe(a);
        strobe(b);
        step(1);
        rst_n = 1'b0;
        @(negedge clk);
        step(0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_tvalid", m_tvalid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_beats", beat_cnt, 2);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(8);
        @(negedge clk);
        chk("post_rst_tvalid", m_tvalid, 1'b0);
        chk("post_rst_beats", beat_cnt, 2);
        step(1);
        a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        beat_cnt = 0;
        push_digest(a);
        strobe(a);
        drain();
        chk("post_rst_new_beats", beat_cnt, 5);

        // ---------------- final report ----------------
        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
